test_status_monitor: RTL and testbench
======================================

// Module: test_status_monitor
// PURPOSE
// - Hardware end of the riscv-tests pass/fail convention: snoops the Core data-memory bus and
//   retirement PC, decides PASS/FAIL/TIMEOUT, and presents a sticky status the bench or an FPGA LED reads.
// - Sits beside Core and memory at the top level; passive on writes, answers reads of its status word.
// - Replaces bench-side PC/register polling with a synthesizable, cycle-exact verdict.
// PARAMETERS
// - TOHOST_ADDR     32'h0000_1000  byte address of the tohost mailbox word
// - END_PC          32'h0000_0044  PC at which the test's final gp (x3) value is judged
// - TIMEOUT_CYCLES  5000           RUN cycles before a TIMEOUT verdict; 0 disables the watchdog
// PORTS
// - clk          in   1   single clock, all logic on posedge
// - rst          in   1   synchronous, active-high reset
// - start        in   1   IDLE->RUN; ignored in every other state
// - pc           in   32  Core program counter of the current cycle
// - gp           in   32  Core register x3 (test-number / result register)
// - mem_we       in   1   data store strobe
// - mem_re       in   1   data load strobe
// - mem_addr     in   32  data byte address (word aligned)
// - mem_wdata    in   32  store data
// - stat_rdata   out  32  status word for a load of TOHOST_ADDR
// - stat_rvalid  out  1   stat_rdata valid; exactly 1 cycle after a hitting load
// - done         out  1   sticky: verdict reached
// - pass         out  1   sticky: verdict is PASS
// - timeout      out  1   sticky: verdict is TIMEOUT
// - fail_test    out  31  failing test number (0 unless FAIL)
// - cycles       out  32  RUN cycle count, frozen at verdict
// BEHAVIOUR
// - Reset: state=IDLE; done, pass, timeout, stat_rvalid=0; fail_test, cycles, stat_rdata=0. rst wins
//   over every other input, including mid-RUN and after a verdict.
// - States: IDLE -(start)-> RUN -(event)-> PASS | FAIL | TIMEOUT. The three verdicts are terminal until rst.
// - RUN: cycles increments by 1 every RUN cycle, saturating at 32'hFFFF_FFFF. The start cycle counts as 0.
// - Tohost event: RUN and mem_we and mem_addr==TOHOST_ADDR.
//   - wdata==1 -> PASS.
//   - wdata[0]==1, wdata!=1 -> FAIL, fail_test=wdata[31:1].
//   - wdata[0]==0 -> ignored (no syscall proxy), stay in RUN.
// - End-PC event: RUN and pc==END_PC. gp==1 -> PASS; otherwise FAIL with fail_test=gp[31:1].
// - Watchdog: RUN and TIMEOUT_CYCLES!=0 and cycles==TIMEOUT_CYCLES-1 -> TIMEOUT.
// - Same-cycle priority: tohost > end-PC > watchdog. Exactly one verdict is taken.
// - Verdict latency: outputs are registered. Event in cycle N -> done/pass/timeout/fail_test visible
//   at N+1. cycles holds the count of cycle N.
// - Status read: mem_re and mem_addr==TOHOST_ADDR in any state -> stat_rvalid=1 at N+1.
//   stat_rdata = {fail_test, pass} when done, else 0. Reads never change state.
// - A simultaneous mem_we and mem_re to TOHOST_ADDR: the write is evaluated, and the read returns the
//   pre-write status.
// - Stores and loads to other addresses, and all events outside RUN, have no effect.
// STRUCTURE
// - Shared package/header tsm_defs.vh: state encoding (IDLE=3'd0, RUN=3'd1, PASS=3'd2,
//   FAIL=3'd3, TIMEOUT=3'd4) and the default TOHOST_ADDR constant, also used by the memory map.
// - One sub-module: tsm_watchdog (saturating counter with compare/expire output). All other logic
//   is a single FSM in test_status_monitor.
// TESTING
// - rst, start, then a store of 32'h1 to TOHOST_ADDR at RUN cycle 10 -> next cycle done=1, pass=1,
//   cycles=10, fail_test=0.
// - A store of 32'h7 to TOHOST_ADDR -> done=1, pass=0, fail_test=3. A later store of 32'h1 leaves the
//   status unchanged.
// - pc=32'h44 with gp=32'h1 -> PASS. Separately, pc=32'h44 with gp=32'h9 -> FAIL, fail_test=4.
// - Same cycle: store 32'h5 to tohost, pc=END_PC, gp=1 -> FAIL with fail_test=2 (tohost priority).
// - No event with TIMEOUT_CYCLES=5000 -> done=1, timeout=1 one cycle after RUN cycle 4999, cycles=4999.
//   A store of 32'h2 to tohost is ignored throughout.
// - After a verdict, a load of TOHOST_ADDR -> stat_rvalid=1 one cycle later with the status word.
//   Then rst for 1 cycle -> all outputs 0, state IDLE; a store before start is ignored.

Source files
------------

// File: rtl/tsm_defs_pkg.sv
// Shared definitions for the test status monitor.
// Holds the FSM state encoding, the default tohost mailbox address (also used
// by the memory map), and a helper that packs the status word a load returns.
package tsm_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } tsm_state_e;

  localparam logic [31:0] TSM_TOHOST_ADDR = 32'h0000_1000;

  // Status word layout: {failing test number, pass flag}.
  function automatic logic [31:0] tsm_status_word(input logic [30:0] fail_test,
                                                  input logic        pass);
    return {fail_test, pass};
  endfunction

endpackage

// File: rtl/tsm_watchdog.sv
// Saturating RUN-cycle counter with watchdog compare.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - load the counter with 0 (start of a run)
//   en        - advance the counter by 1, saturating at all-ones
//   count     - current count
//   expire    - count has reached LIMIT-1 (never asserts when LIMIT is 0)
module tsm_watchdog #(
  parameter int unsigned LIMIT = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  output logic [31:0] count,
  output logic        expire
);

  localparam logic [31:0] LAST = 32'(LIMIT - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && count != '1) begin
      count <= count + 32'd1;
    end
  end

  assign expire = (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/test_status_monitor.sv
// Test status monitor: snoops the core data bus and retirement PC to reach a
// sticky PASS / FAIL / TIMEOUT verdict following the riscv-tests tohost
// convention, and answers loads of the tohost word with the status.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - IDLE->RUN
//   pc, gp       - core PC and register x3 of the current cycle
//   mem_we/re    - data store / load strobes
//   mem_addr     - data byte address
//   mem_wdata    - store data
//   stat_rdata   - status word, valid with stat_rvalid one cycle after a load hit
//   done/pass/timeout - sticky verdict flags
//   fail_test    - failing test number (0 unless FAIL)
//   cycles       - RUN cycle count, frozen at verdict
module test_status_monitor
  import tsm_defs_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = TSM_TOHOST_ADDR,
  parameter logic [31:0] END_PC         = 32'h0000_0044,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic [31:0] gp,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] stat_rdata,
  output logic        stat_rvalid,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] fail_test,
  output logic [31:0] cycles
);

  tsm_state_e  state, state_next;
  logic [30:0] fail_next;
  logic        tohost_wr, tohost_rd, end_hit, wd_expire;

  assign tohost_wr = mem_we && (mem_addr == TOHOST_ADDR);
  assign tohost_rd = mem_re && (mem_addr == TOHOST_ADDR);
  assign end_hit   = (pc == END_PC);

  // Counter advances only while the run continues, so on the verdict cycle it
  // holds the count of that cycle.
  tsm_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ST_IDLE && start),
    .en    (state == ST_RUN && state_next == ST_RUN),
    .count (cycles),
    .expire(wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fail_test <= '0;
    end else begin
      state     <= state_next;
      fail_test <= fail_next;
    end
  end

  // Priority chain: tohost store, then end PC, then watchdog.
  always_comb begin
    state_next = state;
    fail_next  = fail_test;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (tohost_wr && mem_wdata[0]) begin
          if (mem_wdata == 32'd1) begin
            state_next = ST_PASS;
          end else begin
            state_next = ST_FAIL;
            fail_next  = mem_wdata[31:1];
          end
        end else if (end_hit) begin
          if (gp == 32'd1) begin
            state_next = ST_PASS;
          end else begin
            state_next = ST_FAIL;
            fail_next  = gp[31:1];
          end
        end else if (wd_expire) begin
          state_next = ST_TIMEOUT;
        end
      end
      default: state_next = state;
    endcase
  end

  assign done    = (state == ST_PASS) || (state == ST_FAIL) || (state == ST_TIMEOUT);
  assign pass    = (state == ST_PASS);
  assign timeout = (state == ST_TIMEOUT);

  // Reads sample the registered status, so a same-cycle store is not yet visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rvalid <= 1'b0;
      stat_rdata  <= '0;
    end else begin
      stat_rvalid <= tohost_rd;
      stat_rdata  <= (tohost_rd && done) ? tsm_status_word(fail_test, pass) : '0;
    end
  end

endmodule

// File: tb/tb_test_status_monitor.sv
module tb_test_status_monitor;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam logic [31:0] ENDPC  = 32'h0000_0044;
  localparam int unsigned TMO    = 5000;

  logic        clk = 1'b0;
  logic        rst, start, mem_we, mem_re;
  logic [31:0] pc, gp, mem_addr, mem_wdata;
  logic [31:0] stat_rdata, cycles;
  logic        stat_rvalid, done, pass, timeout;
  logic [30:0] fail_test;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  test_status_monitor #(
    .TOHOST_ADDR   (TOHOST),
    .END_PC        (ENDPC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pc         (pc),
    .gp         (gp),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stat_rdata (stat_rdata),
    .stat_rvalid(stat_rvalid),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .fail_test  (fail_test),
    .cycles     (cycles)
  );

  // Reference model: verdict 0=none 1=pass 2=fail 3=timeout.
  int          m_verdict;
  bit          m_running;
  longint      m_count;
  int unsigned m_fail;
  bit          m_rvalid;
  int unsigned m_rdata;

  task automatic model_edge();
    if (rst) begin
      m_verdict = 0; m_running = 0; m_count = 0; m_fail = 0;
      m_rvalid = 0; m_rdata = 0;
      return;
    end
    m_rvalid = mem_re && (mem_addr == TOHOST);
    m_rdata  = (m_rvalid && m_verdict != 0) ? ((m_fail << 1) | (m_verdict == 1 ? 1 : 0)) : 0;
    if (m_verdict == 0 && !m_running) begin
      if (start) begin m_running = 1; m_count = 0; end
    end else if (m_running) begin
      if (mem_we && mem_addr == TOHOST && mem_wdata[0]) begin
        if (mem_wdata == 1) m_verdict = 1;
        else begin m_verdict = 2; m_fail = mem_wdata >> 1; end
      end else if (pc == ENDPC) begin
        if (gp == 1) m_verdict = 1;
        else begin m_verdict = 2; m_fail = gp >> 1; end
      end else if (TMO != 0 && m_count == TMO - 1) begin
        m_verdict = 3;
      end
      if (m_verdict != 0) m_running = 0;
      else if (m_count < 64'hFFFF_FFFF) m_count++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_done"},    {31'd0, done},       {31'd0, m_verdict != 0});
    chk({tag, "_pass"},    {31'd0, pass},       {31'd0, m_verdict == 1});
    chk({tag, "_timeout"}, {31'd0, timeout},    {31'd0, m_verdict == 3});
    chk({tag, "_fail"},    {1'b0, fail_test},   m_fail);
    chk({tag, "_cycles"},  cycles,              32'(m_count));
    chk({tag, "_rvalid"},  {31'd0, stat_rvalid}, {31'd0, m_rvalid});
    if (m_rvalid) chk({tag, "_rdata"}, stat_rdata, m_rdata);
  endtask

  // One clock: model samples the same inputs as the DUT, outputs checked #1 later.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; pc = 0; gp = 0;
    mem_we = 0; mem_re = 0; mem_addr = 0; mem_wdata = 0;
  endtask

  task automatic do_reset_start(input string tag);
    idle_inputs(); rst = 1;
    cyc({tag, "_rst"});
    rst = 0; start = 1;
    cyc({tag, "_start"});
    start = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1; mem_addr = a; mem_wdata = d;
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    cyc("reset0");
    cyc("reset1");
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_cycles", cycles, 32'd0);

    // Store of 1 at RUN cycle 10.
    do_reset_start("t1");
    repeat (10) cyc("t1_run");
    store(TOHOST, 32'h1);
    cyc("t1_pass");
    idle_inputs();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_passbit", {31'd0, pass}, 32'd1);
    chk("t1_cyc10", cycles, 32'd10);
    chk("t1_fail0", {1'b0, fail_test}, 32'd0);

    // Store 7 -> FAIL 3, later store 1 ignored, then status read.
    do_reset_start("t2");
    repeat (3) cyc("t2_run");
    store(TOHOST, 32'h7);
    cyc("t2_fail");
    store(TOHOST, 32'h1);
    cyc("t2_sticky");
    idle_inputs();
    chk("t2_pass0", {31'd0, pass}, 32'd0);
    chk("t2_fail3", {1'b0, fail_test}, 32'd3);
    mem_re = 1; mem_addr = TOHOST;
    cyc("t2_read");
    idle_inputs();
    chk("t2_rvalid", {31'd0, stat_rvalid}, 32'd1);
    chk("t2_rdata", stat_rdata, 32'h6);
    cyc("t2_rdone");

    // End-PC pass and fail.
    do_reset_start("t3");
    repeat (2) cyc("t3_run");
    pc = ENDPC; gp = 32'h1;
    cyc("t3_end");
    idle_inputs();
    chk("t3_pass", {31'd0, pass}, 32'd1);
    do_reset_start("t4");
    pc = ENDPC; gp = 32'h9;
    cyc("t4_end");
    idle_inputs();
    chk("t4_fail4", {1'b0, fail_test}, 32'd4);
    chk("t4_pass0", {31'd0, pass}, 32'd0);

    // Tohost beats end-PC in the same cycle.
    do_reset_start("t5");
    store(TOHOST, 32'h5); pc = ENDPC; gp = 32'h1;
    cyc("t5_prio");
    idle_inputs();
    chk("t5_fail2", {1'b0, fail_test}, 32'd2);
    chk("t5_pass0", {31'd0, pass}, 32'd0);

    // Simultaneous store of 1 and load: read sees pre-write status (0).
    do_reset_start("t6");
    store(TOHOST, 32'h1); mem_re = 1;
    cyc("t6_rw");
    idle_inputs();
    chk("t6_rvalid", {31'd0, stat_rvalid}, 32'd1);
    chk("t6_rdata", stat_rdata, 32'd0);
    chk("t6_pass", {31'd0, pass}, 32'd1);

    // Watchdog with even stores ignored; bounded wait.
    do_reset_start("t7");
    n = 0;
    while (!done && n < 6000) begin
      if (n % 97 == 0) store(TOHOST, 32'h2); else idle_inputs();
      cyc("t7_run");
      n++;
    end
    idle_inputs();
    chk("t7_timeout", {31'd0, timeout}, 32'd1);
    chk("t7_cycles", cycles, 32'd4999);
    chk("t7_latency", n, 32'd5000);

    // One-cycle reset after verdict, store before start ignored.
    rst = 1;
    cyc("t8_rst");
    rst = 0;
    chk("t8_done0", {31'd0, done}, 32'd0);
    chk("t8_cycles0", cycles, 32'd0);
    store(TOHOST, 32'h1);
    cyc("t8_prestart");
    idle_inputs();
    chk("t8_ignored", {31'd0, done}, 32'd0);
    repeat (3) cyc("t8_idle");

    // Randomized runs against the model.
    for (int r = 0; r < 30; r++) begin
      do_reset_start("rnd");
      for (int c = 0; c < 150; c++) begin
        mem_we    = ($urandom_range(0, 15) == 0);
        mem_re    = ($urandom_range(0, 3) == 0);
        mem_addr  = ($urandom_range(0, 1) == 0) ? TOHOST : 32'h0000_2000;
        mem_wdata = $urandom_range(0, 15);
        pc        = ($urandom_range(0, 60) == 0) ? ENDPC : {$urandom_range(0, 15), 2'b00};
        gp        = $urandom_range(0, 15);
        start     = ($urandom_range(0, 7) == 0);
        rst       = ($urandom_range(0, 200) == 0);
        cyc("rnd");
      end
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
